// File: rtl/inst_queue_if.sv
// Fetch-side push and decode-side issue signals of the instruction queue.
// The master modport is the fetch/decode side and the slave modport is the queue.
interface inst_queue_if;
    logic        inst_rdy;
    logic [31:0] inst_in;
    logic [31:0] pc_in;
    logic        iqueue_full;
    logic        issue_ready;
    logic        out_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;

    modport master (
        output inst_rdy, inst_in, pc_in, issue_ready,
        input  iqueue_full, out_valid, inst_out, pc_out
    );

    modport slave (
        input  inst_rdy, inst_in, pc_in, issue_ready,
        output iqueue_full, out_valid, inst_out, pc_out
    );
endinterface

// File: rtl/inst_queue.sv
// Circular {inst, pc} FIFO between fetch and decode/issue, with show-ahead head,
// early full flag, flush on redirect and a sticky overflow error.
module inst_queue #(
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         clear,
    inst_queue_if.slave  iq,
    output logic         overflow_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [31:0]       inst_mem_r [DEPTH];
    logic [31:0]       pc_mem_r   [DEPTH];
    logic [ADDR_W-1:0] head_r;
    logic [ADDR_W-1:0] tail_r;
    logic [ADDR_W:0]   count_r;
    logic              overflow_r;

    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              write_en_s;

    // Handshake decode: a pop frees a slot, so a push alongside it is legal even when full.
    always_comb begin
        pop_s      = 1'b0;
        push_s     = 1'b0;
        drop_s     = 1'b0;
        write_en_s = 1'b0;
        if (count_r != CNT_ZERO) begin
            pop_s = iq.issue_ready;
        end else begin
            pop_s = 1'b0;
        end
        if (iq.inst_rdy && ((count_r < CNT_DEPTH) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (iq.inst_rdy && (count_r == CNT_DEPTH) && !pop_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
        if (!rst && rdy && !clear && push_s) begin
            write_en_s = 1'b1;
        end else begin
            write_en_s = 1'b0;
        end
    end

    // Entry storage; contents are only meaningful between head and tail, so no reset.
    always_ff @(posedge clk) begin
        if (write_en_s) begin
            inst_mem_r[tail_r] <= iq.inst_in;
            pc_mem_r[tail_r]   <= iq.pc_in;
        end
    end

    // Pointer, occupancy and sticky error state: rst, then freeze, then flush, then push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r     <= PTR_ZERO;
            tail_r     <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else if (!rdy) begin
            head_r     <= head_r;
            tail_r     <= tail_r;
            count_r    <= count_r;
            overflow_r <= overflow_r;
        end else if (clear) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Early full leaves one slot for the push fetch already has in flight.
    assign iq.iqueue_full = (count_r >= CNT_FULL);
    assign iq.out_valid   = (count_r != CNT_ZERO);
    assign iq.inst_out    = inst_mem_r[head_r];
    assign iq.pc_out      = pc_mem_r[head_r];
    assign overflow_err   = overflow_r;
endmodule
